// File: rtl/cdc_stream_pkg.sv
// Shared definitions for the FIFO stream reader: width helpers, default
// parameter values and the credit-invariant check macro.
// Optional feature macro used by the top level: CDC_FIFO_STREAM_READER_COUNT_EN.
package cdc_stream_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_READ_LATENCY = 1;
   localparam int DEFAULT_BUF_DEPTH    = 4;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   // Pointer width for a circular buffer of the given depth (never zero).
   function automatic int ptr_width(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   // Occupancy width: one extra bit so that "full" (== depth) is representable.
   function automatic int count_width(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// Credit invariant: words buffered plus words still in the RAM read pipeline
// never exceed the buffer size. Checked every cycle outside reset.
`ifndef SYNTHESIS
`define CDC_STREAM_CREDIT_ASSERT(clk_s, rst_s, used_s, limit_s) \
   always_ff @(posedge clk_s) begin \
      if (!(rst_s)) begin \
         assert ((used_s) <= (limit_s)) \
            else $error("credit invariant broken: occupancy + inflight = %0d", (used_s)); \
      end \
   end
`else
`define CDC_STREAM_CREDIT_ASSERT(clk_s, rst_s, used_s, limit_s)
`endif

// File: rtl/stream_buffer.sv
// Circular output buffer for the FIFO stream reader. One write port (landing
// RAM data), one read port (stream head), occupancy count output.
// Head data is read combinationally so the stream sees the word the cycle
// after it is written.
module stream_buffer
   import cdc_stream_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int BUF_DEPTH  = DEFAULT_BUF_DEPTH,
   localparam int PTR_W      = ptr_width(BUF_DEPTH),
   localparam int CNT_W      = count_width(BUF_DEPTH)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [CNT_W-1:0]      o_count
);

   logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_rd_fire;

   // A read of an empty buffer is ignored so the count cannot underflow.
   assign w_rd_fire = i_rd_en && (r_count != '0);

   // Storage: entries are cleared on reset so the head reads 0 afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because BUF_DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: a simultaneous write and read leaves the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         case ({i_wr_en, w_rd_fire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/cdc_fifo_stream_reader.sv
// Read-side consumer of the dual-clock FIFO. Pops words with req/empty/data,
// tracks the RAM read latency with a valid-bit pipeline, and lands the words
// in a small buffer that feeds a valid/ready stream at one word per cycle.
// Pops are credit-limited: buffered + in-flight words never exceed BUF_DEPTH,
// so nothing popped is ever dropped.
// Optional feature: define CDC_FIFO_STREAM_READER_COUNT_EN to add
// o_word_count, a wrapping 32-bit count of accepted stream transfers.
module cdc_fifo_stream_reader
   import cdc_stream_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
   parameter int BUF_DEPTH    = DEFAULT_BUF_DEPTH
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_req,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready
`ifdef CDC_FIFO_STREAM_READER_COUNT_EN
   ,
   output logic [31:0]           o_word_count
`endif
);

   localparam int             CNT_W        = count_width(BUF_DEPTH);
   localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W+1)'(BUF_DEPTH);

   logic [READ_LATENCY-1:0] r_inflight_pipe;
   logic [CNT_W-1:0]        w_occupancy;
   logic [CNT_W-1:0]        w_inflight;
   logic [CNT_W:0]          w_credit_used;
   logic                    w_req;
   logic                    w_land;
   logic                    w_xfer;

   // In-flight count: number of pops whose data has not landed yet.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         w_inflight = w_inflight + CNT_W'(r_inflight_pipe[i]);
      end
   end

   assign w_credit_used = {1'b0, w_occupancy} + {1'b0, w_inflight};

   // Pop only when a buffer slot is guaranteed for the returning word;
   // gated by reset so no pop is issued while state is being cleared.
   assign w_req  = !reset && !i_fifo_empty && (w_credit_used < CREDIT_LIMIT);
   assign w_land = r_inflight_pipe[READ_LATENCY-1];
   assign w_xfer = o_out_valid && i_out_ready;

   // Read-latency pipeline: bit 0 records this cycle's pop, the last bit
   // marks the cycle in which i_fifo_data carries that popped word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight_pipe <= '0;
      end else begin
         r_inflight_pipe <= (r_inflight_pipe << 1) | READ_LATENCY'(w_req);
      end
   end

   stream_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buffer (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_land),
      .i_wr_data (i_fifo_data),
      .i_rd_en   (w_xfer),
      .o_rd_data (o_out_data),
      .o_count   (w_occupancy)
   );

   assign o_fifo_req  = w_req;
   assign o_out_valid = (w_occupancy != '0);

   // Check that the credit scheme keeps the buffer from overflowing.
   `CDC_STREAM_CREDIT_ASSERT(clk, reset, w_credit_used, CREDIT_LIMIT)

`ifdef CDC_FIFO_STREAM_READER_COUNT_EN
   logic [31:0] r_word_count;

   // Transfer counter, wraps at 2^32 and updates the cycle after a transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word_count <= '0;
      end else if (w_xfer) begin
         r_word_count <= r_word_count + 32'd1;
      end
   end

   assign o_word_count = r_word_count;
`endif

endmodule
